mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Round-robin arbiter sharing one picorv32 native memory bus (valid/ready, addr, wdata, wstrb, rdata, instr) between NUM_REQ requesters, e.g. core plus a trace/DMA engine, ahead of the AXI adapter and test memory.
- One transaction in flight at a time; the request is latched at grant.
- A per-transaction watchdog terminates stalled slaves with an error pulse.

Parameters:
- NUM_REQ, 2, number of requesters (2..8); index 0 wins first after reset.
- TIMEOUT, 1024, cycles in BUSY before forced termination; 0 disables the watchdog.
- TIMEOUT_RDATA, 32'hDEAD_BEEF, read data returned on timeout.

Ports:
- clk  in  1  clock, all logic on posedge.
- resetn  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request; held until its req_ready.
- req_instr  in  NUM_REQ  per-requester instruction-fetch flag.
- req_addr  in  32*NUM_REQ  flattened addresses; slice i = [32*i+31:32*i].
- req_wdata  in  32*NUM_REQ  flattened write data.
- req_wstrb  in  4*NUM_REQ  flattened byte strobes; 0 = read.
- req_ready  out  NUM_REQ  one-hot completion pulse.
- req_rdata  out  32  read data, valid while any req_ready bit is 1.
- req_err  out  1  timeout pulse, coincident with req_ready.
- mem_valid  out  1  shared-bus request.
- mem_instr  out  1  latched instr flag.
- mem_addr  out  32  latched address.
- mem_wdata  out  32  latched write data.
- mem_wstrb  out  4  latched strobes.
- mem_ready  in  1  slave completion.
- mem_rdata  in  32  slave read data.
- grant_idx  out  $clog2(NUM_REQ)  current/last owner, for debug and bench.

Behaviour:
- Reset (async assert, sync release): state=IDLE, all outputs 0, last-grant pointer=NUM_REQ-1, watchdog count=0. Reset asserted mid-transaction drops mem_valid immediately; no completion pulse is issued.
- Registered FSM with states IDLE, BUSY, RESP.
- IDLE:
  - Any req_valid selects the first asserted index scanning last+1, last+2, … (mod NUM_REQ).
  - Latch that requester's addr/wdata/wstrb/instr onto mem_*, set grant_idx, mem_valid<=1, go to BUSY.
  - Grant-to-bus latency is 1 cycle.
- BUSY:
  - mem_* are held constant, independent of requester inputs.
  - Watchdog increments each cycle.
  - mem_ready=1: mem_valid<=0, req_rdata<=mem_rdata (passed through for writes too), req_ready[grant]<=1, go to RESP.
  - Watchdog reaches TIMEOUT (TIMEOUT!=0) with mem_ready=0: mem_valid<=0, req_rdata<=TIMEOUT_RDATA, req_err<=1, req_ready[grant]<=1, go to RESP.
  - mem_ready and timeout in the same cycle: mem_ready wins, no error.
- RESP:
  - req_ready and req_err last exactly 1 cycle; req_rdata holds until the next completion.
  - last<=grant, watchdog<=0, go to IDLE.
  - Requester valid seen during RESP is ignored (the requester drops it this cycle).
- Minimum 3 cycles per transaction (IDLE, BUSY with same-cycle mem_ready, RESP). Back-to-back requests from different requesters alternate strictly.
- Requester dropping req_valid during BUSY is a protocol violation. The latched transaction still completes and its req_ready pulse is still issued.
- req_ready is one-hot or zero. mem_valid is never high in IDLE or RESP.
- Write with mem_ready: completes normally; the arbiter itself never modifies strobes or addresses.

Test Plan:
- Single requester 0 read addr 0x100, slave mem_ready 2 cycles after mem_valid with rdata 0x12345678 -> mem_valid 1 cycle after req_valid; req_ready=2'b01 one cycle after mem_ready; req_rdata=0x12345678; req_err=0.
- Both requesters continuously valid (NUM_REQ=2), slave ready immediately -> grants 0,1,0,1 over four transactions; each req_ready pulse 3 cycles apart; grant_idx alternates.
- NUM_REQ=4, requesters 1 and 3 valid, last grant 1 -> next grant 3, then 1; requesters 0 and 2 never get req_ready.
- TIMEOUT=8, slave never ready -> mem_valid high exactly 8 cycles, then req_ready and req_err pulse together with req_rdata=0xDEADBEEF; the next request is arbitrated normally.
- Write wstrb=4'b0011 addr 0x1000_0000 wdata 0x41, requester changes req_addr mid-BUSY -> mem_addr/mem_wdata/mem_wstrb stay 0x1000_0000/0x41/0011 until mem_ready.
- resetn pulsed low during BUSY -> mem_valid and req_ready 0 in the same cycle; after release, requester 0 wins if both requesters are valid.

Source files
------------

// File: rtl/mem_bus_arbiter_if.sv
// Shared-bus bundle between NUM_REQ picorv32-style requesters and one memory
// slave, as seen by the round-robin arbiter.
interface mem_bus_arbiter_if #(
  parameter int NUM_REQ = 2
) ();
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // requester side
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_instr;
  logic [32*NUM_REQ-1:0] req_addr;
  logic [32*NUM_REQ-1:0] req_wdata;
  logic [4*NUM_REQ-1:0]  req_wstrb;
  logic [NUM_REQ-1:0]    req_ready;
  logic [31:0]           req_rdata;
  logic                  req_err;

  // shared memory side
  logic                  mem_valid;
  logic                  mem_instr;
  logic [31:0]           mem_addr;
  logic [31:0]           mem_wdata;
  logic [3:0]            mem_wstrb;
  logic                  mem_ready;
  logic [31:0]           mem_rdata;

  logic [GW-1:0]         grant_idx;

  // arbiter view
  modport slave (
    input  req_valid, req_instr, req_addr, req_wdata, req_wstrb,
    input  mem_ready, mem_rdata,
    output req_ready, req_rdata, req_err,
    output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    output grant_idx
  );

  // requesters + memory view
  modport master (
    output req_valid, req_instr, req_addr, req_wdata, req_wstrb,
    output mem_ready, mem_rdata,
    input  req_ready, req_rdata, req_err,
    input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    input  grant_idx
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one picorv32 native memory bus between NUM_REQ
// requesters. One transaction in flight; request latched at grant; a
// per-transaction watchdog terminates stalled slaves with an error pulse.
module mem_bus_arbiter #(
  parameter int          NUM_REQ       = 2,
  parameter int          TIMEOUT       = 1024,
  parameter logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF
) (
  input logic            clk,
  input logic            resetn,
  mem_bus_arbiter_if.slave bus
);
  localparam int          GW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned NR      = NUM_REQ;
  localparam logic [31:0] WD_LAST = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t             r_state;
  logic [GW-1:0]      r_last;
  logic [GW-1:0]      r_grant;
  logic [31:0]        r_wd;
  logic               r_mem_valid;
  logic               r_mem_instr;
  logic [31:0]        r_mem_addr;
  logic [31:0]        r_mem_wdata;
  logic [3:0]         r_mem_wstrb;
  logic [NUM_REQ-1:0] r_ready;
  logic [31:0]        r_rdata;
  logic               r_err;

  logic [GW-1:0]      w_sel;
  logic [GW-1:0]      w_scan;
  logic               w_any;

  // Round-robin pick: first valid requester scanning last+1 .. last (mod NUM_REQ)
  always_comb begin
    w_sel  = r_last;
    w_scan = '0;
    w_any  = 1'b0;
    for (int unsigned k = 1; k <= NR; k++) begin
      w_scan = GW'((32'(r_last) + k) % NR);
      if (!w_any && bus.req_valid[w_scan]) begin
        w_any = 1'b1;
        w_sel = w_scan;
      end
    end
  end

  // Arbiter FSM with all bus/requester outputs registered
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= IDLE;
      r_last      <= GW'(NR - 1);
      r_grant     <= '0;
      r_wd        <= '0;
      r_mem_valid <= 1'b0;
      r_mem_instr <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_wstrb <= '0;
      r_ready     <= '0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_grant     <= w_sel;
            r_mem_instr <= bus.req_instr[w_sel];
            r_mem_addr  <= bus.req_addr[32*w_sel +: 32];
            r_mem_wdata <= bus.req_wdata[32*w_sel +: 32];
            r_mem_wstrb <= bus.req_wstrb[4*w_sel +: 4];
            r_mem_valid <= 1'b1;
            r_state     <= BUSY;
          end
        end
        BUSY: begin
          r_wd <= r_wd + 32'd1;
          // mem_ready has priority over a watchdog expiring in the same cycle
          if (bus.mem_ready) begin
            r_mem_valid      <= 1'b0;
            r_rdata          <= bus.mem_rdata;
            r_ready[r_grant] <= 1'b1;
            r_state          <= RESP;
          end else if (TIMEOUT != 0 && r_wd == WD_LAST) begin
            r_mem_valid      <= 1'b0;
            r_rdata          <= TIMEOUT_RDATA;
            r_err            <= 1'b1;
            r_ready[r_grant] <= 1'b1;
            r_state          <= RESP;
          end
        end
        RESP: begin
          r_ready <= '0;
          r_err   <= 1'b0;
          r_last  <= r_grant;
          r_wd    <= '0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.mem_valid = r_mem_valid;
  assign bus.mem_instr = r_mem_instr;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_wstrb = r_mem_wstrb;
  assign bus.req_ready = r_ready;
  assign bus.req_rdata = r_rdata;
  assign bus.req_err   = r_err;
  assign bus.grant_idx = r_grant;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter (NUM_REQ=4, TIMEOUT=8). Expected
// completions are queued when requests are issued and popped on req_ready.
module tb_mem_bus_arbiter;
  localparam int N = 4;

  logic clk = 1'b0;
  logic resetn = 1'b0;

  mem_bus_arbiter_if #(.NUM_REQ(N)) bus ();

  mem_bus_arbiter #(
    .NUM_REQ(N),
    .TIMEOUT(8),
    .TIMEOUT_RDATA(32'hDEAD_BEEF)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        instr;
    logic [31:0] rdata;
    logic        err;
    int          gap;
    int          cyc;
  } exp_t;

  exp_t q[$];

  int          n_checks = 0;
  int          n_fail = 0;
  int          rq_left[N];
  logic [31:0] rq_addr[N];
  logic [31:0] rq_wdata[N];
  logic [3:0]  rq_wstrb[N];
  logic        rq_instr[N];
  int          s_delay = 0;
  int          s_cnt = 0;
  logic [31:0] s_xor = '0;
  int          cyc = 0;
  int          last_pulse = 0;
  bit          prev_pulse = 0;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_wstrb;
  logic        cap_instr;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i]         = (rq_left[i] > 0);
      bus.req_instr[i]         = rq_instr[i];
      bus.req_addr[32*i +: 32] = rq_addr[i];
      bus.req_wdata[32*i +: 32] = rq_wdata[i];
      bus.req_wstrb[4*i +: 4]  = rq_wstrb[i];
    end
  endtask

  task automatic push(input int idx, input logic [31:0] rdata, input logic err,
                      input int gap, input int cycles);
    exp_t e;
    e.idx   = idx;
    e.addr  = rq_addr[idx];
    e.wdata = rq_wdata[idx];
    e.wstrb = rq_wstrb[idx];
    e.instr = rq_instr[idx];
    e.rdata = rdata;
    e.err   = err;
    e.gap   = gap;
    e.cyc   = cycles;
    q.push_back(e);
  endtask

  // One cycle: observe outputs at negedge, run the slave and requester models
  task automatic tick();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (prev_pulse) begin
      check_eq("ready_one_cycle", 32'(bus.req_ready), 32'd0);
      check_eq("err_one_cycle", 32'(bus.req_err), 32'd0);
      prev_pulse = 0;
    end
    if (|bus.req_ready) begin
      if (q.size() == 0) begin
        check_eq("unexpected_ready", 32'(bus.req_ready), 32'd0);
      end else begin
        e = q.pop_front();
        check_eq("ready_onehot", 32'(bus.req_ready), 32'(1 << e.idx));
        check_eq("grant_idx", 32'(bus.grant_idx), 32'(e.idx));
        check_eq("rdata", bus.req_rdata, e.rdata);
        check_eq("err", 32'(bus.req_err), 32'(e.err));
        if (e.gap > 0) check_eq("pulse_gap", 32'(cyc - last_pulse), 32'(e.gap));
        if (e.cyc > 0) check_eq("valid_cycles", 32'(s_cnt), 32'(e.cyc));
        if (rq_left[e.idx] > 0) rq_left[e.idx]--;
      end
      last_pulse = cyc;
      prev_pulse = 1;
    end
    // slave model
    if (bus.mem_ready) begin
      bus.mem_ready = 1'b0;
    end else if (bus.mem_valid) begin
      s_cnt++;
      if (s_cnt == 1) begin
        cap_addr  = bus.mem_addr;
        cap_wdata = bus.mem_wdata;
        cap_wstrb = bus.mem_wstrb;
        cap_instr = bus.mem_instr;
        if (q.size() > 0) begin
          check_eq("mem_addr", bus.mem_addr, q[0].addr);
          check_eq("mem_wdata", bus.mem_wdata, q[0].wdata);
          check_eq("mem_wstrb", 32'(bus.mem_wstrb), 32'(q[0].wstrb));
          check_eq("mem_instr", 32'(bus.mem_instr), 32'(q[0].instr));
        end
      end else begin
        check_eq("hold_addr", bus.mem_addr, cap_addr);
        check_eq("hold_wdata", bus.mem_wdata, cap_wdata);
        check_eq("hold_wstrb", 32'(bus.mem_wstrb), 32'(cap_wstrb));
        check_eq("hold_instr", 32'(bus.mem_instr), 32'(cap_instr));
      end
      if (s_cnt == s_delay) begin
        bus.mem_ready = 1'b1;
        bus.mem_rdata = bus.mem_addr ^ s_xor;
      end
    end
    if (!bus.mem_valid) s_cnt = 0;
    drive();
  endtask

  task automatic wait_done(input int bound);
    for (int n = 0; n < bound && q.size() > 0; n++) tick();
    check_eq("scoreboard_drained", 32'(q.size()), 32'd0);
    tick();
    tick();
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    q.delete();
    for (int i = 0; i < N; i++) rq_left[i] = 0;
    bus.mem_ready = 1'b0;
    s_cnt = 0;
    prev_pulse = 0;
    drive();
    tick();
    tick();
    check_eq("rst_mem_valid", 32'(bus.mem_valid), 32'd0);
    check_eq("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check_eq("rst_req_err", 32'(bus.req_err), 32'd0);
    check_eq("rst_grant_idx", 32'(bus.grant_idx), 32'd0);
    check_eq("rst_req_rdata", bus.req_rdata, 32'd0);
    check_eq("rst_mem_addr", bus.mem_addr, 32'd0);
    resetn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    for (int i = 0; i < N; i++) begin
      rq_left[i]  = 0;
      rq_addr[i]  = 32'h2000 + 32'(16 * i);
      rq_wdata[i] = '0;
      rq_wstrb[i] = '0;
      rq_instr[i] = 1'b0;
    end
    drive();

    // single read from requester 0, slave ready after 2 cycles
    do_reset();
    rq_addr[0]  = 32'h0000_0100;
    rq_instr[0] = 1'b1;
    s_delay = 2;
    s_xor   = 32'h1234_5778;
    push(0, 32'h1234_5678, 1'b0, 0, 2);
    rq_left[0] = 1;
    drive();
    tick();
    check_eq("grant_latency", 32'(bus.mem_valid), 32'd1);
    wait_done(50);
    rq_instr[0] = 1'b0;

    // two requesters continuously valid, immediate slave: 0,1,0,1
    do_reset();
    rq_addr[0] = 32'h2000;
    rq_addr[1] = 32'h2010;
    s_delay = 1;
    s_xor   = 32'h5A5A_0000;
    push(0, 32'h2000 ^ s_xor, 1'b0, 0, 1);
    push(1, 32'h2010 ^ s_xor, 1'b0, 3, 1);
    push(0, 32'h2000 ^ s_xor, 1'b0, 3, 1);
    push(1, 32'h2010 ^ s_xor, 1'b0, 3, 1);
    rq_left[0] = 2;
    rq_left[1] = 2;
    drive();
    wait_done(100);

    // requesters 1 and 3 after last grant 1: 3,1,3,1
    rq_addr[1] = 32'h3100;
    rq_addr[3] = 32'h3300;
    push(3, 32'h3300 ^ s_xor, 1'b0, 0, 1);
    push(1, 32'h3100 ^ s_xor, 1'b0, 3, 1);
    push(3, 32'h3300 ^ s_xor, 1'b0, 3, 1);
    push(1, 32'h3100 ^ s_xor, 1'b0, 3, 1);
    rq_left[1] = 2;
    rq_left[3] = 2;
    drive();
    wait_done(100);

    // stalled slave: watchdog after 8 cycles, then normal arbitration
    rq_addr[2] = 32'h4000;
    s_delay = 0;
    push(2, 32'hDEAD_BEEF, 1'b1, 0, 8);
    rq_left[2] = 1;
    drive();
    wait_done(50);
    rq_addr[0] = 32'h4400;
    s_delay = 3;
    push(0, 32'h4400 ^ s_xor, 1'b0, 0, 3);
    rq_left[0] = 1;
    drive();
    wait_done(50);

    // write with requester inputs changing mid-BUSY
    rq_addr[1]  = 32'h1000_0000;
    rq_wdata[1] = 32'h0000_0041;
    rq_wstrb[1] = 4'b0011;
    s_delay = 5;
    push(1, 32'h1000_0000 ^ s_xor, 1'b0, 0, 5);
    rq_left[1] = 1;
    drive();
    tick();
    tick();
    tick();
    rq_addr[1]  = 32'hFFFF_0000;
    rq_wdata[1] = 32'h0;
    rq_wstrb[1] = 4'b1111;
    drive();
    wait_done(50);

    // reset asserted during BUSY
    s_delay = 0;
    rq_left[0] = 1;
    rq_left[1] = 1;
    drive();
    tick();
    tick();
    tick();
    check_eq("pre_rst_busy", 32'(bus.mem_valid), 32'd1);
    #2 resetn = 1'b0;
    #1;
    check_eq("midrst_mem_valid", 32'(bus.mem_valid), 32'd0);
    check_eq("midrst_req_ready", 32'(bus.req_ready), 32'd0);
    check_eq("midrst_grant_idx", 32'(bus.grant_idx), 32'd0);
    bus.mem_ready = 1'b0;
    tick();
    tick();
    s_delay = 1;
    push(0, rq_addr[0] ^ s_xor, 1'b0, 0, 1);
    push(1, rq_addr[1] ^ s_xor, 1'b0, 3, 1);
    resetn = 1'b1;
    wait_done(50);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
